// File: rtl/fsmc_pin_frontend_pkg.sv
// Shared types and constants for the FSMC pad front end.
//   state_t      - front-end FSM states
//   BE_*         - byte-enable encodings as presented on req_be
//   ADR_W/DAT_W  - pad address/data widths
package fsmc_pin_frontend_pkg;

   localparam int ADR_W = 16;
   localparam int DAT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_RD_REQ,
      ST_RD_DRIVE,
      ST_WAIT_REL
   } state_t;

   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_BOTH = 2'b11;

   // Pad lanes are active low; req_be is active high.
   function automatic logic [1:0] be_from_pads(input logic ub_n, input logic lb_n);
      return ~{ub_n, lb_n};
   endfunction

endpackage

// File: rtl/fsmc_pin_frontend_if.sv
// Request/response port between the pad front end and fsmc_module.
//   req_stb/req_we/req_adr/req_dat/req_be : request, driven by the front end
//   req_ack/rsp_dat                       : completion and read data, driven downstream
// master = front end, slave = downstream consumer.
interface fsmc_pin_frontend_if;
   import fsmc_pin_frontend_pkg::*;

   logic             req_stb;
   logic             req_we;
   logic [ADR_W-1:0] req_adr;
   logic [DAT_W-1:0] req_dat;
   logic [1:0]       req_be;
   logic             req_ack;
   logic [DAT_W-1:0] rsp_dat;

   modport master (
      output req_stb, req_we, req_adr, req_dat, req_be,
      input  req_ack, rsp_dat
   );

   modport slave (
      input  req_stb, req_we, req_adr, req_dat, req_be,
      output req_ack, rsp_dat
   );
endinterface

// File: rtl/fsmc_pin_frontend_sync.sv
// N-stage flop synchroniser for asynchronous pad strobes.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input vector
//   q        : synchronised output, STAGES clocks behind d
// Flops reset to 1 so active-low strobes read as deasserted out of reset.
module fsmc_pin_frontend_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] ff [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) ff[i] <= '1;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/fsmc_pin_frontend.sv
// Front end between raw async-SRAM style FSMC pads and the fsmc_module request port.
// Strobes are synchronised and must hold steady before adr/dat/byte lanes are captured;
// one request is issued per host access and read data is driven back while oe_n is low.
//   clk, rst          : system clock, synchronous active-high reset
//   fsmc_adr/dat_in   : async pad address and write data (sampled only after settle)
//   fsmc_dat_out/oe   : pad read data and tristate enable (1 = drive)
//   fsmc_*_n          : async active-low strobes ce/we/oe and byte lanes ub/lb
//   req               : request port (master side)
//   timeout           : one-cycle pulse when a request is abandoned without ack
//   busy              : high whenever the FSM is not idle
//
// state       | meaning
// ST_IDLE     | waiting for settled strobes of a new host access
// ST_WR_REQ   | write request outstanding
// ST_RD_REQ   | read request outstanding
// ST_RD_DRIVE | driving read data onto the pad until host releases
// ST_WAIT_REL | access finished or refused; waiting for host release
module fsmc_pin_frontend
   import fsmc_pin_frontend_pkg::*;
#(
   parameter int              SYNC_STAGES   = 2,
   parameter int              SETTLE_CYCLES = 2,
   parameter int              TIMEOUT       = 255,
   parameter logic [DAT_W-1:0] TIMEOUT_DATA = 16'hDEAD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADR_W-1:0] fsmc_adr,
   input  logic [DAT_W-1:0] fsmc_dat_in,
   output logic [DAT_W-1:0] fsmc_dat_out,
   output logic             fsmc_dat_oe,
   input  logic             fsmc_ce_n,
   input  logic             fsmc_we_n,
   input  logic             fsmc_oe_n,
   input  logic             fsmc_ub_n,
   input  logic             fsmc_lb_n,
   fsmc_pin_frontend_if.master req,
   output logic             timeout,
   output logic             busy
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state, state_nxt;
   logic [4:0]       strb_s, strb_prev;
   logic [SW-1:0]    settle_cnt;
   logic [TW-1:0]    to_cnt;
   logic             ce_s, we_s, oe_s, settled, host_rd_active, in_req;
   logic [1:0]       be_s;
   logic             cap_req, cap_dat, rd_load, to_fire;
   logic [DAT_W-1:0] rd_data;
   logic [ADR_W-1:0] adr_q;
   logic [DAT_W-1:0] dat_q;
   logic [1:0]       be_q;

   fsmc_pin_frontend_sync #(.WIDTH(5), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n}),
      .q   (strb_s)
   );

   assign ce_s           = strb_s[4];
   assign we_s           = strb_s[3];
   assign oe_s           = strb_s[2];
   assign be_s           = be_from_pads(strb_s[1], strb_s[0]);
   // Any strobe or lane change reloads the settle timer, so a full quiet window is required.
   assign settled        = (strb_s == strb_prev) && (settle_cnt == '0);
   assign host_rd_active = !ce_s && !oe_s;
   assign in_req         = (state == ST_WR_REQ) || (state == ST_RD_REQ);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap_req   = 1'b0;
      cap_dat   = 1'b0;
      rd_load   = 1'b0;
      rd_data   = req.rsp_dat;
      to_fire   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (settled && !ce_s) begin
               if (!we_s && !oe_s) begin
                  state_nxt = ST_WAIT_REL;
               end else if (!we_s) begin
                  if (be_s == BE_NONE) begin
                     state_nxt = ST_WAIT_REL;
                  end else begin
                     cap_req   = 1'b1;
                     cap_dat   = 1'b1;
                     state_nxt = ST_WR_REQ;
                  end
               end else if (!oe_s) begin
                  cap_req   = 1'b1;
                  state_nxt = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            if (req.req_ack) begin
               state_nxt = ST_WAIT_REL;
            end else if (to_cnt == '0) begin
               to_fire   = 1'b1;
               state_nxt = ST_WAIT_REL;
            end
         end
         ST_RD_REQ: begin
            // Ack on the expiry cycle counts as a normal completion.
            if (req.req_ack || (to_cnt == '0)) begin
               to_fire   = !req.req_ack;
               rd_load   = 1'b1;
               rd_data   = req.req_ack ? req.rsp_dat : TIMEOUT_DATA;
               // Host already gone: never touch the pad for this access.
               state_nxt = host_rd_active ? ST_RD_DRIVE : ST_IDLE;
            end
         end
         ST_RD_DRIVE: begin
            if (!host_rd_active) state_nxt = ST_IDLE;
         end
         ST_WAIT_REL: begin
            if (ce_s || (we_s && oe_s)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         strb_prev    <= '1;
         settle_cnt   <= '0;
         to_cnt       <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         be_q         <= BE_NONE;
         fsmc_dat_out <= '0;
         timeout      <= 1'b0;
      end else begin
         strb_prev <= strb_s;
         if (strb_s != strb_prev)    settle_cnt <= SW'(SETTLE_CYCLES - 1);
         else if (settle_cnt != '0)  settle_cnt <= settle_cnt - SW'(1);
         if (cap_req) begin
            adr_q  <= fsmc_adr;
            be_q   <= be_s;
            to_cnt <= TW'(TIMEOUT - 1);
         end else if (in_req && (to_cnt != '0)) begin
            to_cnt <= to_cnt - TW'(1);
         end
         if (cap_dat) dat_q <= fsmc_dat_in;
         if (rd_load) fsmc_dat_out <= rd_data;
         timeout <= to_fire;
      end
   end

   assign req.req_stb = in_req;
   assign req.req_we  = (state == ST_WR_REQ);
   assign req.req_adr = adr_q;
   assign req.req_dat = dat_q;
   assign req.req_be  = be_q;
   assign fsmc_dat_oe = (state == ST_RD_DRIVE);
   assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_fsmc_pin_frontend.sv
module tb_fsmc_pin_frontend;
   import fsmc_pin_frontend_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fsmc_adr, fsmc_dat_in, fsmc_dat_out;
   logic        fsmc_dat_oe, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n;
   logic        timeout, busy;
   logic        stb_d = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          stb_rises = 0;
   int          oe_cycles = 0;
   int          k, n, saved;

   fsmc_pin_frontend_if bus();

   fsmc_pin_frontend #(
      .SYNC_STAGES(2), .SETTLE_CYCLES(2), .TIMEOUT(16), .TIMEOUT_DATA(16'hDEAD)
   ) dut (
      .clk(clk), .rst(rst),
      .fsmc_adr(fsmc_adr), .fsmc_dat_in(fsmc_dat_in),
      .fsmc_dat_out(fsmc_dat_out), .fsmc_dat_oe(fsmc_dat_oe),
      .fsmc_ce_n(fsmc_ce_n), .fsmc_we_n(fsmc_we_n), .fsmc_oe_n(fsmc_oe_n),
      .fsmc_ub_n(fsmc_ub_n), .fsmc_lb_n(fsmc_lb_n),
      .req(bus), .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      stb_d <= bus.req_stb;
      if (bus.req_stb && !stb_d) stb_rises <= stb_rises + 1;
      if (fsmc_dat_oe) oe_cycles <= oe_cycles + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pads(input logic ce, input logic we, input logic oe, input logic ub, input logic lb);
      fsmc_ce_n = ce; fsmc_we_n = we; fsmc_oe_n = oe; fsmc_ub_n = ub; fsmc_lb_n = lb;
   endtask

   task automatic wait_stb(output int cnt);
      cnt = 0;
      while (!bus.req_stb && cnt < 30) begin tick(); cnt++; end
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 30) begin tick(); cnt++; end
   endtask

   initial begin
      rst = 1'b1;
      fsmc_adr = '0; fsmc_dat_in = '0;
      pads(1, 1, 1, 1, 1);
      bus.req_ack = 1'b0; bus.rsp_dat = '0;
      repeat (3) tick();
      check("rst_stb", bus.req_stb, 0);
      check("rst_oe", fsmc_dat_oe, 0);
      check("rst_dat_out", fsmc_dat_out, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      check("rst_adr", bus.req_adr, 0);
      rst = 1'b0;
      repeat (3) tick();

      // 1: write, lower lane, ack 3 cycles after stb
      fsmc_adr = 16'hAAAA; fsmc_dat_in = 16'h5555;
      pads(0, 0, 1, 1, 0);
      wait_stb(k);
      check("wr_latency", k, 5);
      check("wr_we", bus.req_we, 1);
      check("wr_adr", bus.req_adr, 16'hAAAA);
      check("wr_dat", bus.req_dat, 16'h5555);
      check("wr_be", bus.req_be, BE_LO);
      check("wr_busy", busy, 1);
      fsmc_adr = 16'h1234; fsmc_dat_in = 16'h0000;
      tick(); tick();
      check("wr_adr_hold", bus.req_adr, 16'hAAAA);
      check("wr_dat_hold", bus.req_dat, 16'h5555);
      check("wr_stb_held", bus.req_stb, 1);
      bus.req_ack = 1'b1; tick(); bus.req_ack = 1'b0;
      check("wr_stb_drop", bus.req_stb, 0);
      tick(); tick();
      check("wr_wait_rel_busy", busy, 1);
      check("wr_one_req", stb_rises, 1);
      pads(1, 1, 1, 1, 1);
      wait_idle(k);
      check("wr_release", k, 3);
      repeat (3) tick();

      // 2: read, upper lane, ack with FEDC
      fsmc_adr = 16'h9876;
      pads(0, 1, 0, 0, 1);
      wait_stb(k);
      check("rd_latency", k, 5);
      check("rd_we", bus.req_we, 0);
      check("rd_adr", bus.req_adr, 16'h9876);
      check("rd_be", bus.req_be, BE_HI);
      tick(); tick();
      bus.req_ack = 1'b1; bus.rsp_dat = 16'hFEDC; tick(); bus.req_ack = 1'b0;
      check("rd_stb_drop", bus.req_stb, 0);
      check("rd_oe", fsmc_dat_oe, 1);
      check("rd_dat_out", fsmc_dat_out, 16'hFEDC);
      bus.rsp_dat = 16'h0000;
      tick(); tick();
      check("rd_oe_hold", fsmc_dat_oe, 1);
      check("rd_dat_hold", fsmc_dat_out, 16'hFEDC);
      pads(0, 1, 1, 0, 1);
      k = 0;
      while (fsmc_dat_oe && k < 30) begin tick(); k++; end
      check("rd_oe_release", k, 3);
      check("rd_idle", busy, 0);
      pads(1, 1, 1, 1, 1);
      repeat (4) tick();
      check("rd_one_req", stb_rises, 2);

      // 3: read with no ack -> timeout after 16 cycles, host sees DEAD
      fsmc_adr = 16'h0100;
      pads(0, 1, 0, 0, 0);
      wait_stb(k);
      check("to_latency", k, 5);
      check("to_be", bus.req_be, BE_BOTH);
      n = 0;
      while (!timeout && n < 40) begin tick(); n++; end
      check("to_cycles", n, 16);
      check("to_stb", bus.req_stb, 0);
      check("to_oe", fsmc_dat_oe, 1);
      check("to_dat", fsmc_dat_out, 16'hDEAD);
      tick();
      check("to_pulse_width", timeout, 0);
      pads(1, 1, 1, 1, 1);
      wait_idle(k);
      check("to_release", k, 3);
      repeat (3) tick();

      // 3b: ack on the expiry cycle wins over timeout
      fsmc_adr = 16'h0300;
      pads(0, 1, 0, 1, 0);
      wait_stb(k);
      check("tie_latency", k, 5);
      repeat (15) tick();
      check("tie_stb_still", bus.req_stb, 1);
      bus.req_ack = 1'b1; bus.rsp_dat = 16'hBEEF; tick(); bus.req_ack = 1'b0;
      check("tie_no_pulse", timeout, 0);
      check("tie_oe", fsmc_dat_oe, 1);
      check("tie_dat", fsmc_dat_out, 16'hBEEF);
      pads(1, 1, 1, 1, 1);
      wait_idle(k);
      check("tie_release", k, 3);
      repeat (3) tick();

      // 4: we_n and oe_n both low -> no request, busy until ce_n rises
      saved = stb_rises;
      pads(0, 0, 0, 1, 1);
      repeat (10) tick();
      check("ill_no_req", stb_rises, saved);
      check("ill_busy", busy, 1);
      pads(1, 0, 0, 1, 1);
      wait_idle(k);
      check("ill_release", k, 3);
      pads(1, 1, 1, 1, 1);
      repeat (4) tick();

      // 4b: write with no byte lanes -> no request
      pads(0, 0, 1, 1, 1);
      repeat (10) tick();
      check("be0_no_req", stb_rises, saved);
      check("be0_busy", busy, 1);
      pads(1, 1, 1, 1, 1);
      wait_idle(k);
      check("be0_release", k, 3);
      repeat (3) tick();

      // 5: reset while req_stb is high
      fsmc_adr = 16'h0500;
      pads(0, 1, 0, 0, 0);
      wait_stb(k);
      check("rst_mid_stb_up", bus.req_stb, 1);
      saved = stb_rises + 1;
      rst = 1'b1;
      pads(1, 1, 1, 1, 1);
      tick();
      check("rst_mid_stb", bus.req_stb, 0);
      check("rst_mid_oe", fsmc_dat_oe, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_adr", bus.req_adr, 0);
      rst = 1'b0;
      tick();
      bus.req_ack = 1'b1; bus.rsp_dat = 16'h7777; tick(); bus.req_ack = 1'b0;
      tick(); tick();
      check("rst_ack_ignored_busy", busy, 0);
      check("rst_ack_ignored_oe", fsmc_dat_oe, 0);
      check("rst_ack_ignored_dat", fsmc_dat_out, 0);
      check("rst_ack_no_req", stb_rises, saved);

      // 6: host releases before ack -> completes on ack, pad never driven
      fsmc_adr = 16'h0600;
      pads(0, 1, 0, 0, 0);
      wait_stb(k);
      check("abt_latency", k, 5);
      saved = oe_cycles;
      pads(1, 1, 1, 1, 1);
      repeat (4) tick();
      check("abt_stb_pending", bus.req_stb, 1);
      bus.req_ack = 1'b1; bus.rsp_dat = 16'h1111; tick(); bus.req_ack = 1'b0;
      check("abt_stb_drop", bus.req_stb, 0);
      check("abt_idle", busy, 0);
      check("abt_oe_now", fsmc_dat_oe, 0);
      repeat (3) tick();
      check("abt_oe_never", oe_cycles, saved);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
